rr_arbiter_m: RTL and testbench
===============================

// Module: rr_arbiter_m
// PURPOSE
//  Round-robin arbiter that shares one resource among NUM_REQ requesters.
//  Winner selection is a pointer-masked find-first-set: the lowest set request
//  at index >= ptr wins; if there is none, the lowest set request overall wins.
//  A grant is held until the owner drops its request, or until an optional
//  MAX_HOLD timeout revokes it. Sits in front of any shared datapath port.
// PARAMETERS
//  NUM_REQ   8  number of requesters; values <1 are treated as 1.
//  MAX_HOLD  0  maximum cycles gnt may stay high per grant; 0 = no timeout.
// PORTS
//  clk        in   1                         clock; all logic on rising edge
//  rst_n      in   1                         synchronous reset, active-low
//  en         in   1                         1 = new grants allowed
//  req        in   NUM_REQ                   level request per requester
//  gnt        out  NUM_REQ                   one-hot grant; registered
//  gnt_valid  out  1                         |gnt; registered
//  gnt_idx    out  $clog2(max(NUM_REQ,2))    index of the granted bit; 0 when no grant
//  timeout    out  1                         one-cycle pulse when a grant is revoked
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): gnt=0, gnt_valid=0, gnt_idx=0, timeout=0,
//   ptr=0, hold_cnt=0, state=IDLE. This applies mid-grant too; the grant is
//   dropped at that edge.
//  States:
//   IDLE:  at each edge with en=1 and |req=1, the winner w is registered.
//          gnt=1<<w, gnt_idx=w, gnt_valid=1, hold_cnt=0, go to GRANT.
//          Latency is 1 cycle from sampled req to gnt.
//          en=0 or req=0: stay in IDLE with outputs 0.
//   GRANT: en is ignored. The req bits of non-owners are ignored.
//          The owner is g = gnt_idx.
//          Release: req[g]=0 sampled at an edge -> at that edge gnt=0,
//           gnt_valid=0, gnt_idx=0, ptr=(g+1) mod NUM_REQ, go to IDLE.
//          Timeout (MAX_HOLD>0): gnt has been high for MAX_HOLD cycles and
//           req[g] is still 1 -> gnt cleared and ptr advanced exactly as for a
//           release, timeout=1 for that one cycle, go to IDLE.
//           Net effect: gnt is high for at most MAX_HOLD consecutive cycles.
//          Otherwise hold_cnt++, saturating at MAX_HOLD.
//  At least one gnt=0 bubble cycle always separates consecutive grants.
//  Winner selection in IDLE uses the ptr updated at the previous edge.
//  Release and timeout on the same edge: count it as a release; timeout stays 0.
//  Pointer wrap: g = NUM_REQ-1 -> ptr=0.
//  NUM_REQ=1: ptr is always 0 and gnt_idx is 1 bit wide, held at 0.
//  gnt is always one-hot or zero, and gnt_valid == |gnt every cycle.
//  timeout is 0 on every cycle other than a revoke cycle.
//  hold_cnt is $clog2(MAX_HOLD+1) bits wide, with a minimum of 1 bit.
// TESTING
//  1 Release handoff: after reset, set req=8'h05 and hold it.
//    -> next cycle gnt=8'h01, idx 0.
//    Drop req[0] -> gnt=0 for 1 cycle, then gnt=8'h04, idx 2.
//  2 Rotation: req=8'hFF; each owner drops its req after 2 grant cycles and
//    re-raises it 1 cycle later.
//    -> grant idx order 0,1,2,...,7,0. No double grant at any cycle.
//  3 Timeout: MAX_HOLD=4, req=8'h08 held.
//    -> gnt=8'h08 for exactly 4 cycles; timeout pulses 1 cycle as gnt falls;
//    1 bubble cycle; then gnt=8'h08 again.
//  4 Enable: en=0 with req=8'h10 -> gnt stays 0.
//    Raise en -> gnt=8'h10 next cycle.
//    Drop en mid-grant -> gnt is held until req[4] drops.
//  5 Wrap and masking: owner idx 7 releases while req=8'h81 -> next gnt=8'h01.
//    Owner idx 2 releases while req=8'h03 -> next gnt=8'h01 (wrap to lowest).
//  6 Reset mid-grant: ptr=5 and gnt=8'h20, then assert rst_n=0 for 1 edge.
//    -> all outputs 0 at that edge.
//    Release reset with req=8'hFF -> gnt=8'h01.

Source files
------------

// File: rtl/rr_arbiter_m.sv
// Round-robin arbiter: pointer-masked find-first-set winner, grant held until the
// owner drops its request or an optional hold timeout revokes it.
module rr_arbiter_m #(
    parameter int  NUM_REQ  = 8,
    parameter int  MAX_HOLD = 0,
    localparam int N        = (NUM_REQ < 1) ? 1 : NUM_REQ,
    localparam int IW       = $clog2((N < 2) ? 2 : N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    output logic          timeout
);

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [HW-1:0] HOLD_MAX  = HW'((MAX_HOLD > 0) ? MAX_HOLD : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [N-1:0]  gnt_r, gnt_s;
    logic          gnt_valid_r, gnt_valid_s;
    logic [IW-1:0] gnt_idx_r, gnt_idx_s;
    logic          timeout_r, timeout_s;
    logic [IW-1:0] ptr_r, ptr_s;
    logic [HW-1:0] hold_cnt_r, hold_cnt_s;
    logic [IW-1:0] win_lo_s, win_hi_s, win_s, ptr_inc_s;
    logic          hi_found_s, owner_req_s;

    // Winner search: lowest request at or above ptr, otherwise lowest request overall
    always_comb begin
        win_lo_s   = '0;
        win_hi_s   = '0;
        hi_found_s = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            win_lo_s   = req[i] ? IW'(i) : win_lo_s;
            win_hi_s   = (req[i] && (i >= int'(ptr_r))) ? IW'(i) : win_hi_s;
            hi_found_s = (req[i] && (i >= int'(ptr_r))) ? 1'b1 : hi_found_s;
        end
        win_s = hi_found_s ? win_hi_s : win_lo_s;
    end

    // gnt is one-hot on the owner, so this is the owner's own request bit
    assign owner_req_s = |(req & gnt_r);
    assign ptr_inc_s   = (int'(gnt_idx_r) == (N - 1)) ? '0 : (gnt_idx_r + IW'(1));

    // Next-state and next-output logic
    always_comb begin
        state_s     = state_r;
        gnt_s       = gnt_r;
        gnt_valid_s = gnt_valid_r;
        gnt_idx_s   = gnt_idx_r;
        ptr_s       = ptr_r;
        hold_cnt_s  = hold_cnt_r;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (en && (|req)) begin
                    gnt_s       = N'(1'b1) << win_s;
                    gnt_valid_s = 1'b1;
                    gnt_idx_s   = win_s;
                    hold_cnt_s  = '0;
                    state_s     = GRANT;
                end else begin
                    gnt_s       = '0;
                    gnt_valid_s = 1'b0;
                    gnt_idx_s   = '0;
                end
            end
            GRANT: begin
                if (!owner_req_s || ((MAX_HOLD > 0) && (hold_cnt_r == HOLD_LAST))) begin
                    // A release on the revoke edge wins, so timeout only fires when req is still high
                    timeout_s   = owner_req_s;
                    gnt_s       = '0;
                    gnt_valid_s = 1'b0;
                    gnt_idx_s   = '0;
                    ptr_s       = ptr_inc_s;
                    state_s     = IDLE;
                end else begin
                    hold_cnt_s = (hold_cnt_r == HOLD_MAX) ? hold_cnt_r : (hold_cnt_r + HW'(1));
                end
            end
            default: begin
                gnt_s       = '0;
                gnt_valid_s = 1'b0;
                gnt_idx_s   = '0;
                state_s     = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
            gnt_idx_r   <= '0;
            timeout_r   <= 1'b0;
            ptr_r       <= '0;
            hold_cnt_r  <= '0;
        end else begin
            state_r     <= state_s;
            gnt_r       <= gnt_s;
            gnt_valid_r <= gnt_valid_s;
            gnt_idx_r   <= gnt_idx_s;
            timeout_r   <= timeout_s;
            ptr_r       <= ptr_s;
            hold_cnt_r  <= hold_cnt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_valid = gnt_valid_r;
    assign gnt_idx   = gnt_idx_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_m.sv
// Bench for rr_arbiter_m: one untimed instance (a) and one MAX_HOLD=4 instance (b),
// expected {gnt, gnt_valid, gnt_idx, timeout} queued per cycle and popped after each edge.
module tb_rr_arbiter_m;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [7:0] req_a, req_b;
    logic [7:0] gnt_a, gnt_b;
    logic       gv_a, gv_b, to_a, to_b;
    logic [2:0] idx_a, idx_b;
    logic [12:0] obs_a, obs_b;
    logic [12:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_m #(.NUM_REQ(8), .MAX_HOLD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .req(req_a),
        .gnt(gnt_a), .gnt_valid(gv_a), .gnt_idx(idx_a), .timeout(to_a)
    );

    rr_arbiter_m #(.NUM_REQ(8), .MAX_HOLD(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .req(req_b),
        .gnt(gnt_b), .gnt_valid(gv_b), .gnt_idx(idx_b), .timeout(to_b)
    );

    assign obs_a = {gnt_a, gv_a, idx_a, to_a};
    assign obs_b = {gnt_b, gv_b, idx_b, to_b};

    function automatic logic [12:0] pk(input logic [7:0] g, input logic to);
        logic [2:0] ix = 3'd0;
        for (int i = 0; i < 8; i++) if (g[i]) ix = 3'(i);
        return {g, |g, ix, to};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1; req_a = 8'h00; req_b = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1; req_a = 8'hFF; req_b = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(pk(8'h00, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 2;
            if (obs_a !== e) begin errors++; $display("FAIL reset_a[%0d] got %h exp %h", i, obs_a, e); end
            if (obs_b !== e) begin errors++; $display("FAIL reset_b[%0d] got %h exp %h", i, obs_b, e); end
        end
    endtask

    task automatic test_release();
        logic [7:0] rq [6] = '{8'h05, 8'h05, 8'h04, 8'h04, 8'h04, 8'h00};
        logic [7:0] eg [6] = '{8'h01, 8'h01, 8'h00, 8'h04, 8'h04, 8'h00};
        logic [12:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_a = rq[i];
            exp_q.push_back(pk(eg[i], 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin errors++; $display("FAIL release[%0d] got %h exp %h", i, obs_a, e); end
        end
    endtask

    task automatic test_rotation();
        logic [12:0] e;
        logic [7:0]  own;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            own = 8'h01 << (k % 8);
            for (int j = 0; j < 3; j++) begin
                req_a = (j == 2) ? (8'hFF & ~own) : 8'hFF;
                exp_q.push_back(pk((j == 2) ? 8'h00 : own, 1'b0));
                @(posedge clk); #1;
                e = exp_q.pop_front();
                checks++;
                if (obs_a !== e) begin errors++; $display("FAIL rotation[%0d.%0d] got %h exp %h", k, j, obs_a, e); end
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] rq [11] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08};
        logic [7:0] eg [11] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08};
        logic       et [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [12:0] e;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            req_b = rq[i];
            exp_q.push_back(pk(eg[i], et[i]));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs_b !== e) begin errors++; $display("FAIL timeout[%0d] got %h exp %h", i, obs_b, e); end
        end
    endtask

    task automatic test_enable();
        logic       ev [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] rq [11] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h10};
        logic [7:0] eg [11] = '{8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00};
        logic [12:0] e;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            en_a  = ev[i];
            req_a = rq[i];
            exp_q.push_back(pk(eg[i], 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin errors++; $display("FAIL enable[%0d] got %h exp %h", i, obs_a, e); end
        end
    endtask

    task automatic test_wrap_mask();
        logic [7:0] rq [12] = '{8'h80, 8'h81, 8'h01, 8'h81, 8'h00, 8'h04,
                                8'h07, 8'h03, 8'h03, 8'h00, 8'h05, 8'h00};
        logic [7:0] eg [12] = '{8'h80, 8'h80, 8'h00, 8'h01, 8'h00, 8'h04,
                                8'h04, 8'h00, 8'h01, 8'h00, 8'h04, 8'h00};
        logic [12:0] e;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            req_a = rq[i];
            exp_q.push_back(pk(eg[i], 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin errors++; $display("FAIL wrap_mask[%0d] got %h exp %h", i, obs_a, e); end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic       rs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] rq [6] = '{8'h10, 8'h00, 8'h20, 8'h20, 8'hFF, 8'hFF};
        logic [7:0] eg [6] = '{8'h10, 8'h00, 8'h20, 8'h20, 8'h00, 8'h01};
        logic [12:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            rst_n = rs[i];
            req_a = rq[i];
            exp_q.push_back(pk(eg[i], 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin errors++; $display("FAIL reset_mid[%0d] got %h exp %h", i, obs_a, e); end
        end
    endtask

    initial begin
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; req_a = 8'h00; req_b = 8'h00;
        #1;
        test_reset();
        test_release();
        test_rotation();
        test_timeout();
        test_enable();
        test_wrap_mask();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
